wb_button_irq: RTL and testbench



---
 rtl/wb_button_irq_pkg.sv | 25 ++
 rtl/wb_button_irq_button_debouncer.sv | 54 +++++
 rtl/wb_button_irq.sv | 105 ++++++++++
 tb/tb_wb_button_irq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_button_irq_pkg.sv
// rtl/wb_button_irq_pkg.sv - shared register offsets, event bit layout and debounce counter width
package wb_button_irq_pkg;

   localparam logic [3:0] REG_STATUS   = 4'h0;
   localparam logic [3:0] REG_EVENT    = 4'h4;
   localparam logic [3:0] REG_IRQ_EN   = 4'h8;

   localparam int PRESS_BASE   = 0;
   localparam int RELEASE_BASE = 8;
   localparam int DB_CNT_W     = 16;

   // Bits of EVENT/IRQ_EN that belong to an existing button; all others read 0.
   function automatic logic [15:0] event_mask(input int num_buttons);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < num_buttons) begin
            m[PRESS_BASE + i]   = 1'b1;
            m[RELEASE_BASE + i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_button_irq_button_debouncer.sv
// rtl/wb_button_irq_button_debouncer.sv - one button channel: synchroniser, polarity, debounce counter
module button_debouncer
   import wb_button_irq_pkg::*;
#(
   parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd12000,
   parameter bit                  ACTIVE_LOW      = 1'b1
)(
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_stable,
   output logic o_rise_pulse,
   output logic o_fall_pulse
);

   localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);
   localparam logic [DB_CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - CNT_ONE;

   logic                r_meta;
   logic                r_sync;
   logic                r_stable;
   logic [DB_CNT_W-1:0] r_count;
   logic                w_norm;
   logic                w_accept;

   assign w_norm   = r_sync ^ ACTIVE_LOW;
   assign w_accept = (w_norm != r_stable) && (r_count == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta   <= ACTIVE_LOW;
         r_sync   <= ACTIVE_LOW;
         r_stable <= 1'b0;
         r_count  <= '0;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         if (w_norm == r_stable) begin
            r_count <= '0;
         end else if (w_accept) begin
            r_stable <= w_norm;
            r_count  <= '0;
         end else begin
            r_count <= r_count + CNT_ONE;
         end
      end
   end

   // Pulses are combinational so the event register sets on the same edge stable flips.
   assign o_stable     = r_stable;
   assign o_rise_pulse = w_accept & w_norm;
   assign o_fall_pulse = w_accept & ~w_norm;

endmodule

// File: rtl/wb_button_irq.sv
// rtl/wb_button_irq.sv - Wishbone slave with debounced buttons, sticky W1C events and level irq
module wb_button_irq
   import wb_button_irq_pkg::*;
#(
   parameter logic [31:0] address         = 32'h0400_0000,
   parameter int          NUM_BUTTONS     = 3,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd12000,
   parameter bit          ACTIVE_LOW      = 1'b1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_wb_cyc,
   input  logic                   i_wb_stb,
   input  logic                   i_wb_we,
   input  logic [31:0]            i_wb_addr,
   input  logic [31:0]            i_wb_data,
   output logic                   o_wb_ack,
   output logic [31:0]            o_wb_data,
   input  logic [NUM_BUTTONS-1:0] buttons,
   output logic                   irq
);

   localparam logic [15:0] EV_MASK = event_mask(NUM_BUTTONS);

   logic [NUM_BUTTONS-1:0] w_stable;
   logic [NUM_BUTTONS-1:0] w_rise;
   logic [NUM_BUTTONS-1:0] w_fall;
   logic [15:0]            w_set;
   logic                   w_sel;
   logic                   w_access;
   logic [3:0]             w_offset;
   logic [31:0]            w_rdata;
   logic                   w_unused;

   logic [15:0]            r_event;
   logic [15:0]            r_irq_en;
   logic                   r_ack;
   logic [31:0]            r_rdata;
   logic                   r_irq;

   genvar g;
   generate
      for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
         button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
         ) u_debouncer (
            .clk          (clk),
            .reset        (reset),
            .i_pin        (buttons[g]),
            .o_stable     (w_stable[g]),
            .o_rise_pulse (w_rise[g]),
            .o_fall_pulse (w_fall[g])
         );
      end
   endgenerate

   always_comb begin
      w_set = '0;
      w_set[PRESS_BASE   +: NUM_BUTTONS] = w_rise;
      w_set[RELEASE_BASE +: NUM_BUTTONS] = w_fall;
   end

   // The !r_ack term splits a held strobe into separate single-cycle acks.
   assign w_sel    = i_wb_cyc & i_wb_stb & (i_wb_addr[31:4] == address[31:4]);
   assign w_access = w_sel & ~r_ack;
   assign w_offset = {i_wb_addr[3:2], 2'b00};
   assign w_unused = ^{i_wb_addr[1:0], i_wb_data[31:16]};

   always_comb begin
      w_rdata = '0;
      case (w_offset)
         REG_STATUS: w_rdata[NUM_BUTTONS-1:0] = w_stable;
         REG_EVENT:  w_rdata[15:0]            = r_event;
         REG_IRQ_EN: w_rdata[15:0]            = r_irq_en;
         default:    w_rdata                  = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack    <= 1'b0;
         r_rdata  <= '0;
         r_event  <= '0;
         r_irq_en <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_ack   <= w_access;
         r_rdata <= (w_access & ~i_wb_we) ? w_rdata : '0;
         // A new event beats a W1C of the same bit in the same cycle.
         if (w_access && i_wb_we && (w_offset == REG_EVENT))
            r_event <= ((r_event & ~i_wb_data[15:0]) | w_set) & EV_MASK;
         else
            r_event <= (r_event | w_set) & EV_MASK;
         if (w_access && i_wb_we && (w_offset == REG_IRQ_EN))
            r_irq_en <= i_wb_data[15:0] & EV_MASK;
         r_irq <= |(r_event & r_irq_en);
      end
   end

   assign o_wb_ack  = r_ack;
   assign o_wb_data = r_rdata;
   assign irq       = r_irq;

endmodule

// File: tb/tb_wb_button_irq.sv
// tb/tb_wb_button_irq.sv - randomized and directed bench for wb_button_irq against a window-based model
module tb_wb_button_irq;

   localparam int          NB   = 3;
   localparam int          DEB  = 4;
   localparam logic [31:0] BASE = 32'h0400_0000;
   localparam logic [15:0] MASK = 16'h0707;

   logic          clk = 1'b0;
   logic          reset;
   logic          cyc, stb, we;
   logic [31:0]   addr, wdata;
   logic          ack;
   logic [31:0]   rdata;
   logic [NB-1:0] buttons;
   logic          irq;

   always #5 clk = ~clk;

   wb_button_irq #(
      .address         (BASE),
      .NUM_BUTTONS     (NB),
      .DEBOUNCE_CYCLES (16'd4),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_wb_cyc  (cyc),
      .i_wb_stb  (stb),
      .i_wb_we   (we),
      .i_wb_addr (addr),
      .i_wb_data (wdata),
      .o_wb_ack  (ack),
      .o_wb_data (rdata),
      .buttons   (buttons),
      .irq       (irq)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: a channel accepts a new level once its last DEB synchronised samples all disagree with it.
   logic        m_ack, m_irq;
   logic [31:0] m_data;
   logic [15:0] m_event, m_en;
   logic        m_stable [NB];
   logic        m_meta   [NB];
   logic        m_sync   [NB];
   logic        m_win    [NB][DEB];

   always @(posedge clk) begin : model
      logic [15:0] set_v, ev_v;
      logic [31:0] rd_v;
      logic [3:0]  off_v;
      logic        acc_v, norm_v, all_diff;
      set_v = '0;
      if (reset) begin
         m_ack <= 1'b0; m_data <= '0; m_irq <= 1'b0; m_event <= '0; m_en <= '0;
         for (int b = 0; b < NB; b++) begin
            m_meta[b] <= 1'b1; m_sync[b] <= 1'b1; m_stable[b] <= 1'b0;
            for (int k = 0; k < DEB; k++) m_win[b][k] <= 1'b0;
         end
      end else begin
         acc_v = cyc && stb && (addr >= BASE) && (addr < BASE + 32'd16) && !m_ack;
         off_v = addr[3:0] & 4'hC;
         rd_v  = '0;
         if (acc_v && !we) begin
            if (off_v == 4'h0)      for (int b = 0; b < NB; b++) rd_v[b] = m_stable[b];
            else if (off_v == 4'h4) rd_v = {16'h0, m_event};
            else if (off_v == 4'h8) rd_v = {16'h0, m_en};
         end
         for (int b = 0; b < NB; b++) begin
            norm_v   = (m_sync[b] == 1'b0);
            all_diff = (norm_v != m_stable[b]);
            for (int k = 0; k < DEB - 1; k++)
               if (m_win[b][k] == m_stable[b]) all_diff = 1'b0;
            m_win[b][0] <= norm_v;
            for (int k = 1; k < DEB - 1; k++) m_win[b][k] <= m_win[b][k-1];
            if (all_diff) begin
               m_stable[b] <= norm_v;
               set_v[norm_v ? b : 8 + b] = 1'b1;
            end
            m_meta[b] <= buttons[b];
            m_sync[b] <= m_meta[b];
         end
         ev_v = m_event;
         if (acc_v && we && off_v == 4'h4) ev_v = ev_v & ~wdata[15:0];
         m_event <= (ev_v | set_v) & MASK;
         if (acc_v && we && off_v == 4'h8) m_en <= wdata[15:0] & MASK;
         m_irq  <= |(m_event & m_en);
         m_ack  <= acc_v;
         m_data <= rd_v;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (ack !== m_ack) begin bad++; $display("FAIL cyc_ack: got %b want %b at %0t", ack, m_ack, $time); end
         total++;
         if (rdata !== m_data) begin bad++; $display("FAIL cyc_data: got %h want %h at %0t", rdata, m_data, $time); end
         total++;
         if (irq !== m_irq) begin bad++; $display("FAIL cyc_irq: got %b want %b at %0t", irq, m_irq, $time); end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One idle cycle, then a single access; returns at the negedge that sees ack.
   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] q);
      int n;
      n = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 8);
      q = rdata;
      check("ack_latency", n, 1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   logic [31:0] q;

   initial begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      buttons = '1; reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_ack", ack, 0);
      check("reset_irq", irq, 0);
      reset = 1'b0;

      bus(BASE + 0, 0, 0, q); check("rd_status0", q, 0);
      bus(BASE + 4, 0, 0, q); check("rd_event0", q, 0);
      bus(BASE + 8, 0, 0, q); check("rd_irqen0", q, 0);

      // Press button 0: stable flips on the 6th edge after the pin change.
      buttons[0] = 1'b0;
      repeat (4) @(negedge clk);
      bus(BASE + 0, 0, 0, q); check("status_before_flip", q, 0);
      bus(BASE + 0, 0, 0, q); check("status_after_flip", q, 32'h1);
      bus(BASE + 4, 0, 0, q); check("event_press0", q, 32'h1);
      buttons[0] = 1'b1;
      repeat (10) @(negedge clk);
      bus(BASE + 4, 0, 0, q); check("event_release0", q, 32'h101);
      bus(BASE + 0, 0, 0, q); check("status_released", q, 0);
      bus(BASE + 4, 1, 32'h101, q);
      bus(BASE + 4, 0, 0, q); check("event_cleared", q, 0);

      buttons[1] = 1'b0;
      repeat (3) @(negedge clk);
      buttons[1] = 1'b1;
      repeat (10) @(negedge clk);
      bus(BASE + 0, 0, 0, q); check("glitch_status", q, 0);
      bus(BASE + 4, 0, 0, q); check("glitch_event", q, 0);

      bus(BASE + 8, 1, 32'h1, q);
      buttons[2] = 1'b0;
      repeat (10) @(negedge clk);
      check("irq_masked", irq, 0);
      bus(BASE + 4, 0, 0, q); check("event_press2", q, 32'h4);
      bus(BASE + 8, 1, 32'h4, q);
      check("irq_at_en_ack", irq, 0);
      @(negedge clk);
      check("irq_after_en", irq, 1);
      bus(BASE + 4, 1, 32'h4, q);
      check("irq_at_clr_ack", irq, 1);
      @(negedge clk);
      check("irq_after_clr", irq, 0);
      bus(BASE + 4, 0, 0, q); check("event_after_clr", q, 0);
      buttons[2] = 1'b1;
      repeat (10) @(negedge clk);
      bus(BASE + 4, 1, 32'hFFFF, q);
      bus(BASE + 8, 1, 32'h0, q);

      // W1C of PRESS[0] whose ack edge is the debounce edge of a new press.
      bus(BASE + 4, 0, 0, q); check("event_pre_race", q, 0);
      buttons[0] = 1'b0;
      repeat (4) @(negedge clk);
      bus(BASE + 4, 1, 32'h1, q);
      bus(BASE + 4, 0, 0, q); check("set_beats_clear", q, 32'h1);
      buttons[0] = 1'b1;
      repeat (10) @(negedge clk);
      bus(BASE + 4, 1, 32'hFFFF, q);

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0300_0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("foreign_no_ack", ack, 0);
      end
      cyc = 1'b0; stb = 1'b0;

      buttons[1] = 1'b0;
      repeat (10) @(negedge clk);
      bus(BASE + 8, 1, 32'h707, q);
      buttons[1] = 1'b1;
      repeat (10) @(negedge clk);
      check("irq_before_reset", irq, 1);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE + 8; wdata = 32'h707; reset = 1'b1;
      @(negedge clk);
      check("ack_in_reset", ack, 0);
      @(negedge clk);
      check("ack_in_reset2", ack, 0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; reset = 1'b0;
      bus(BASE + 0, 0, 0, q); check("post_reset_status", q, 0);
      bus(BASE + 4, 0, 0, q); check("post_reset_event", q, 0);
      bus(BASE + 8, 0, 0, q); check("post_reset_irqen", q, 0);
      check("post_reset_irq", irq, 0);

      for (int i = 0; i < 2500; i++) begin
         int pmod;
         pmod = ((i / 250) % 2 == 0) ? 4 : 25;
         @(negedge clk);
         for (int b = 0; b < NB; b++)
            if ($urandom_range(pmod - 1) == 0) buttons[b] = ~buttons[b];
         if ($urandom_range(3) == 0)
            bus(BASE + {28'h0, 2'($urandom_range(3)), 2'b00}, 1'($urandom_range(1)),
                $urandom, q);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
